// File: rtl/wb_ram_arbiter.sv
// Two-master, one-slave Wishbone arbiter for the shared block RAM, with cyc-locked round-robin grants.
// Define WB_ARB_TIMEOUT_EN to enable the stalled-slave watchdog (m*_err_o).
module wb_ram_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SW      = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    input  logic [SW-1:0] m0_sel_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    input  logic [SW-1:0] m1_sel_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    output logic [SW-1:0] s_sel_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    output logic [1:0]    gnt_o
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t state;
    logic   last_gnt;
    logic   req0, req1;
    logic   timeout;
    logic   leave_gnt;

    if (TIMEOUT < 2 || TIMEOUT > 256 || SW * 8 != DW) begin : g_bad_params
        $error("wb_ram_arbiter: TIMEOUT must be 2..256 and SW*8 must equal DW");
    end

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    assign leave_gnt = ((state == GNT0) && (!m0_cyc_i || timeout)) ||
                       ((state == GNT1) && (!m1_cyc_i || timeout));

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       state_chg;

    assign state_chg = leave_gnt || ((state == IDLE) && (req0 || req1));
    assign timeout   = (state != IDLE) && (to_cnt == 8'(TIMEOUT - 1));

    // Counts only stalled strobe cycles; any ack, idle strobe or grant change restarts it.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            to_cnt <= '0;
        end else if (state_chg || s_ack_i || !s_stb_o) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            gnt_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 && (!req1 || last_gnt)) begin
                        state <= GNT0;
                        gnt_o <= 2'b01;
                    end else if (req1) begin
                        state <= GNT1;
                        gnt_o <= 2'b10;
                    end
                end
                GNT0: begin
                    if (leave_gnt) begin
                        last_gnt <= 1'b0;
                        if (req1 && !timeout) begin
                            state <= GNT1;
                            gnt_o <= 2'b10;
                        end else begin
                            state <= IDLE;
                            gnt_o <= 2'b00;
                        end
                    end
                end
                GNT1: begin
                    if (leave_gnt) begin
                        last_gnt <= 1'b1;
                        if (req0 && !timeout) begin
                            state <= GNT0;
                            gnt_o <= 2'b01;
                        end else begin
                            state <= IDLE;
                            gnt_o <= 2'b00;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_o <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        case (state)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_dat_o = s_dat_i;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_dat_o = s_dat_i;
            end
            default: ;
        endcase
    end

    assign m0_ack_o = s_ack_i & (state == GNT0) & m0_stb_i & ~timeout;
    assign m1_ack_o = s_ack_i & (state == GNT1) & m1_stb_i & ~timeout;
    assign m0_err_o = timeout & (state == GNT0);
    assign m1_err_o = timeout & (state == GNT1);

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Self-checking bench for wb_ram_arbiter: directed scenarios plus a randomized run
// against a round-robin ownership model.
module tb_wb_ram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int SV = 3 + AW + DW + SW;

    logic          clk;
    logic          rst;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i;
    logic [SW-1:0] m0_sel_i;
    logic [DW-1:0] m0_dat_o;
    logic          m0_ack_o, m0_err_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i;
    logic [SW-1:0] m1_sel_i;
    logic [DW-1:0] m1_dat_o;
    logic          m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [SW-1:0] s_sel_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i;
    logic [1:0]    gnt_o;

    logic          ack_en;
    int            checks = 0;
    int            errors = 0;
    int            owner;
    int            last;

    wb_ram_arbiter #(.AW(AW), .DW(DW), .SW(SW), .TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block-RAM style slave: ack one cycle after a strobe, single-cycle pulses.
    always @(posedge clk or posedge rst) begin
        if (rst) s_ack_i <= 1'b0;
        else     s_ack_i <= ack_en & s_stb_o & ~s_ack_i;
    end

    task automatic idle_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        ack_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        owner = -1;
        last  = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        s_dat_i = 32'h1234_5678;
        #1;
        checks++;
        if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt_o); end
        checks++;
        if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o} !== '0) begin
            errors++; $display("FAIL reset_slave: got %h expected 0", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o});
        end
        checks++;
        if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o} !== '0) begin
            errors++; $display("FAIL reset_master: got %h expected 0", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o});
        end
        do_reset();
    endtask

    task automatic test_single_read();
        @(negedge clk);
        ack_en = 1'b1;
        s_dat_i = 32'hCAFE_0123;
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h100; m0_sel_i = 4'hF;
        @(posedge clk); #1;
        checks++;
        if (gnt_o !== 2'b01 || s_stb_o !== 1'b1 || s_adr_o !== 32'h100) begin
            errors++; $display("FAIL read_grant: got gnt=%b stb=%b adr=%h expected 01 1 100", gnt_o, s_stb_o, s_adr_o);
        end
        checks++;
        if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            errors++; $display("FAIL read_early_ack: got %b%b expected 00", m0_ack_o, m1_ack_o);
        end
        @(posedge clk); #1;
        checks++;
        if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
            errors++; $display("FAIL read_ack: got m0=%b m1=%b expected 1 0", m0_ack_o, m1_ack_o);
        end
        checks++;
        if (m0_dat_o !== 32'hCAFE_0123 || m1_dat_o !== '0) begin
            errors++; $display("FAIL read_data: got m0=%h m1=%h expected cafe0123 0", m0_dat_o, m1_dat_o);
        end
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        checks++;
        if (gnt_o !== 2'b00 || m1_ack_o !== 1'b0) begin
            errors++; $display("FAIL read_release: got gnt=%b m1_ack=%b expected 00 0", gnt_o, m1_ack_o);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ack_en = 1'b1;
        @(negedge clk);
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h40;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h80;
        @(posedge clk); #1;
        checks++;
        if (gnt_o !== 2'b01) begin errors++; $display("FAIL tie_first: got %b expected 01", gnt_o); end
        @(negedge clk);
        m0_cyc_i = 0; m0_stb_i = 0;
        @(posedge clk); #1;
        checks++;
        if (gnt_o !== 2'b10 || s_adr_o !== 32'h80) begin
            errors++; $display("FAIL handover: got gnt=%b adr=%h expected 10 80", gnt_o, s_adr_o);
        end
        @(negedge clk);
        m0_cyc_i = 1; m0_stb_i = 1;
        for (int b = 0; b < 3; b++) begin
            @(posedge clk); #1;
            checks++;
            if (gnt_o !== 2'b10 || m0_ack_o !== 1'b0 || m0_dat_o !== '0) begin
                errors++; $display("FAIL m0_waits beat %0d: got gnt=%b ack0=%b expected 10 0", b, gnt_o, m0_ack_o);
            end
        end
        @(negedge clk);
        m1_cyc_i = 0; m1_stb_i = 0;
        @(posedge clk); #1;
        checks++;
        if (gnt_o !== 2'b01) begin errors++; $display("FAIL return_m0: got %b expected 01", gnt_o); end
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        @(negedge clk);
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1;
        m1_sel_i = 4'b0011; m1_dat_i = 32'hDEAD_BEEF; m1_adr_i = 32'h2004;
        #1;
        checks++;
        if (s_sel_o !== 4'b0000 || s_stb_o !== 1'b0 || gnt_o !== 2'b00) begin
            errors++; $display("FAIL idle_quiet: got sel=%b stb=%b gnt=%b expected 0000 0 00", s_sel_o, s_stb_o, gnt_o);
        end
        @(posedge clk); #1;
        checks++;
        if ({s_we_o, s_sel_o, s_dat_o, s_adr_o} !== {1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h2004}) begin
            errors++; $display("FAIL write_path: got we=%b sel=%b dat=%h adr=%h expected 1 0011 deadbeef 2004",
                               s_we_o, s_sel_o, s_dat_o, s_adr_o);
        end
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'hF; m1_adr_i = 32'h8;
        s_dat_i = 32'h5555_AAAA;
        @(posedge clk); #1;
        checks++;
        if (gnt_o !== 2'b10) begin errors++; $display("FAIL pre_reset_gnt: got %b expected 10", gnt_o); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o} !== '0) begin
            errors++; $display("FAIL async_reset_slave: got gnt=%b stb=%b sel=%b expected 00 0 0", gnt_o, s_stb_o, s_sel_o);
        end
        checks++;
        if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o} !== '0) begin
            errors++; $display("FAIL async_reset_master: got ack=%b%b dat1=%h expected 00 0", m0_ack_o, m1_ack_o, m1_dat_o);
        end
        m0_cyc_i = 1; m0_stb_i = 1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (gnt_o !== 2'b01) begin errors++; $display("FAIL post_reset_tie: got %b expected 01", gnt_o); end
        do_reset();
    endtask

    task automatic test_stall();
        ack_en = 1'b0;
        @(negedge clk);
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h300;
`ifdef WB_ARB_TIMEOUT_EN
        begin
            int n;
            int err_at;
            n = 0;
            err_at = -1;
            for (int i = 0; i < 60 && err_at < 0; i++) begin
                @(posedge clk); #1;
                if (s_stb_o) n++;
                if (m1_err_o) begin
                    err_at = n;
                    checks++;
                    if (m1_ack_o !== 1'b0) begin errors++; $display("FAIL err_no_ack: got %b expected 0", m1_ack_o); end
                end
            end
            checks++;
            if (err_at != 16) begin errors++; $display("FAIL timeout_cycle: got %0d expected 16", err_at); end
            @(negedge clk);
            idle_inputs();
            @(posedge clk); #1;
            checks++;
            if (gnt_o !== 2'b00 || m1_err_o !== 1'b0) begin
                errors++; $display("FAIL timeout_idle: got gnt=%b err=%b expected 00 0", gnt_o, m1_err_o);
            end
        end
`else
        for (int i = 0; i < 110; i++) begin
            @(posedge clk); #1;
            checks++;
            if (gnt_o !== 2'b10 || m1_err_o !== 1'b0 || m1_ack_o !== 1'b0) begin
                errors++; $display("FAIL stall_hold cycle %0d: got gnt=%b err=%b ack=%b expected 10 0 0", i, gnt_o, m1_err_o, m1_ack_o);
            end
        end
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
`endif
        do_reset();
    endtask

    task automatic test_random();
        logic [SV-1:0] sv_exp;
        logic [3:0]    flags_exp;
        logic [DW-1:0] d0_exp, d1_exp;
        logic [1:0]    gnt_exp;
        logic [1:0]    req, cyc;
        int            c;
        do_reset();
        for (int cyc_n = 0; cyc_n < 400; cyc_n++) begin
            @(negedge clk);
            ack_en   = ($urandom_range(0, 3) != 0);
            s_dat_i  = $urandom;
            m0_cyc_i = m0_cyc_i ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 4);
            m0_stb_i = m0_cyc_i ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            m0_we_i  = 1'($urandom); m0_adr_i = $urandom; m0_dat_i = $urandom; m0_sel_i = 4'($urandom);
            m1_cyc_i = m1_cyc_i ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 4);
            m1_stb_i = m1_cyc_i ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            m1_we_i  = 1'($urandom); m1_adr_i = $urandom; m1_dat_i = $urandom; m1_sel_i = 4'($urandom);
            #1;
            sv_exp = '0; flags_exp = '0; d0_exp = '0; d1_exp = '0; gnt_exp = 2'b00;
            if (owner == 0) begin
                sv_exp    = {m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i};
                gnt_exp   = 2'b01;
                flags_exp = {2'b00, 1'b0, s_ack_i & m0_stb_i};
                d0_exp    = s_dat_i;
            end else if (owner == 1) begin
                sv_exp    = {m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i};
                gnt_exp   = 2'b10;
                flags_exp = {2'b00, s_ack_i & m1_stb_i, 1'b0};
                d1_exp    = s_dat_i;
            end
            checks++;
            if (gnt_o !== gnt_exp) begin errors++; $display("FAIL rnd_gnt @%0d: got %b expected %b", cyc_n, gnt_o, gnt_exp); end
            checks++;
            if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o} !== sv_exp) begin
                errors++; $display("FAIL rnd_slave @%0d: got %h expected %h", cyc_n,
                                   {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o}, sv_exp);
            end
            checks++;
            if ({m1_err_o, m0_err_o, m1_ack_o, m0_ack_o} !== flags_exp) begin
                errors++; $display("FAIL rnd_ack @%0d: got %b expected %b", cyc_n, {m1_err_o, m0_err_o, m1_ack_o, m0_ack_o}, flags_exp);
            end
            checks++;
            if (m0_dat_o !== d0_exp || m1_dat_o !== d1_exp) begin
                errors++; $display("FAIL rnd_rdata @%0d: got %h/%h expected %h/%h", cyc_n, m0_dat_o, m1_dat_o, d0_exp, d1_exp);
            end
            @(posedge clk);
            req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
            cyc = {m1_cyc_i, m0_cyc_i};
            // Owner keeps the bus while its cyc is high; otherwise offer it to the
            // requesters in round-robin order starting after the last one served.
            if (owner >= 0 && !cyc[owner]) begin
                last  = owner;
                owner = -1;
            end
            if (owner < 0) begin
                for (int k = 1; k <= 2; k++) begin
                    c = (last + k) % 2;
                    if (req[c]) begin
                        owner = c;
                        break;
                    end
                end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        ack_en = 1'b0;
        s_dat_i = '0;
        owner = -1;
        last = 1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_write();
        test_async_reset();
        test_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
